// File: rtl/ariscv_run_sequencer_if.sv
// rtl/ariscv_run_sequencer_if.sv - run-control and stage-clock bundle between SoC and ariscv_run_sequencer
// ARISCV_SEQ_PERF_EN adds the per-stage edge counters and max-stall observation signals.
interface ariscv_run_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             i_start;
  logic             i_stop;
  logic [5:0]       i_aclk;
  logic             o_ctrl_rst_n;
  logic             o_busy;
  logic             o_done;
  logic             o_timeout;
  logic [CNT_W-1:0] o_retired;
  logic [2:0]       o_state;
`ifdef ARISCV_SEQ_PERF_EN
  logic [95:0]      o_stage_cnt;
  logic [15:0]      o_max_stall;
`endif

  modport master (
    output i_start, i_stop, i_aclk,
`ifdef ARISCV_SEQ_PERF_EN
    input  o_stage_cnt, o_max_stall,
`endif
    input  o_ctrl_rst_n, o_busy, o_done, o_timeout, o_retired, o_state
  );

  modport slave (
    input  i_start, i_stop, i_aclk,
`ifdef ARISCV_SEQ_PERF_EN
    output o_stage_cnt, o_max_stall,
`endif
    output o_ctrl_rst_n, o_busy, o_done, o_timeout, o_retired, o_state
  );
endinterface

// File: rtl/ariscv_run_sequencer.sv
// rtl/ariscv_run_sequencer.sv - clocked run controller and deadlock watchdog for the async RISC-V control path
// Optional ARISCV_SEQ_PERF_EN: per-stage rising-edge counters and largest-stall tracking.
module ariscv_run_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int RST_HOLD_CYCLES = 8,
  parameter int WDOG_CYCLES     = 1024,
  parameter int DRAIN_QUIET     = 16,
  parameter int PC_BIT          = 0,
  parameter int MAX_INSTR       = 0,
  parameter int CNT_W           = 32
) (
  input logic                   clk,
  input logic                   rst_async,
  ariscv_run_sequencer_if.slave bus
);

  localparam int HOLD_W  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int WDOG_W  = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int QUIET_W = (DRAIN_QUIET > 1) ? $clog2(DRAIN_QUIET) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);
  localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(DRAIN_QUIET - 1);
  localparam logic [CNT_W-1:0]   LIMIT      = CNT_W'(MAX_INSTR);
  localparam bit                 LIMIT_EN   = (MAX_INSTR != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_e;

  state_e                          state_q, state_d;
  logic [HOLD_W-1:0]               hold_q, hold_d;
  logic [WDOG_W-1:0]               wdog_q, wdog_d;
  logic [QUIET_W-1:0]              quiet_q, quiet_d;
  logic [CNT_W-1:0]                retired_q, retired_d;
  logic                            timeout_q, timeout_d;
  logic                            ctrl_rst_n_q, ctrl_rst_n_d;
  logic [SYNC_STAGES-1:0][5:0]     sync_q;
  logic [5:0]                      prev_q;

  logic [5:0] sync_out;
  logic [5:0] rise;
  logic       any_edge;
  logic       active;
  logic       start_req;
  logic       fault_hit;
  logic       limit_hit;

  // Stage clocks are fully asynchronous: plain flop chain, then one more flop to find edges.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.i_aclk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign rise      = sync_out & ~prev_q;
  assign any_edge  = |(sync_out ^ prev_q);
  assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign start_req = bus.i_start && ((state_q == ST_IDLE) || (state_q == ST_FAULT));
  assign fault_hit = !any_edge && (wdog_q == WDOG_LAST);
  assign limit_hit = LIMIT_EN && (retired_q >= LIMIT);

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      wdog_q       <= '0;
      quiet_q      <= '0;
      retired_q    <= '0;
      timeout_q    <= 1'b0;
      ctrl_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      wdog_q       <= wdog_d;
      quiet_q      <= quiet_d;
      retired_q    <= retired_d;
      timeout_q    <= timeout_d;
      ctrl_rst_n_q <= ctrl_rst_n_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    wdog_d       = wdog_q;
    quiet_d      = quiet_q;
    retired_d    = retired_q;
    timeout_d    = timeout_q;
    ctrl_rst_n_d = 1'b0;

    if (active) begin
      if (rise[PC_BIT] && (retired_q != '1)) retired_d = retired_q + 1'b1;
      wdog_d = any_edge ? '0 : wdog_q + 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_FAULT: begin
        if (start_req) begin
          state_d   = ST_HOLD;
          hold_d    = HOLD_LOAD;
          retired_d = '0;
          timeout_d = 1'b0;
          wdog_d    = '0;
          quiet_d   = '0;
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) begin
          state_d      = ST_RUN;
          ctrl_rst_n_d = 1'b1;
          wdog_d       = '0;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_RUN: begin
        ctrl_rst_n_d = 1'b1;
        // Deadlock outranks a stop or limit landing on the same cycle.
        if (fault_hit) begin
          state_d      = ST_FAULT;
          timeout_d    = 1'b1;
          ctrl_rst_n_d = 1'b0;
        end else if (bus.i_stop || limit_hit) begin
          state_d = ST_DRAIN;
          quiet_d = '0;
        end
      end
      ST_DRAIN: begin
        ctrl_rst_n_d = 1'b1;
        quiet_d      = any_edge ? '0 : quiet_q + 1'b1;
        if (fault_hit) begin
          state_d      = ST_FAULT;
          timeout_d    = 1'b1;
          ctrl_rst_n_d = 1'b0;
        end else if (!any_edge && (quiet_q == QUIET_LAST)) begin
          state_d      = ST_DONE;
          ctrl_rst_n_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_ctrl_rst_n = ctrl_rst_n_q;
  assign bus.o_busy       = (state_q == ST_HOLD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_timeout    = timeout_q;
  assign bus.o_retired    = retired_q;
  assign bus.o_state      = state_q;

`ifdef ARISCV_SEQ_PERF_EN
  logic [5:0][15:0] stage_cnt_q, stage_cnt_d;
  logic [15:0]      max_stall_q, max_stall_d;
  logic [15:0]      stall_now;

  assign stall_now = (32'(wdog_q) > 32'hFFFF) ? 16'hFFFF : 16'(wdog_q);

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      stage_cnt_q <= '0;
      max_stall_q <= '0;
    end else begin
      stage_cnt_q <= stage_cnt_d;
      max_stall_q <= max_stall_d;
    end
  end

  always_comb begin
    stage_cnt_d = stage_cnt_q;
    max_stall_d = max_stall_q;
    if (start_req) begin
      stage_cnt_d = '0;
      max_stall_d = '0;
    end else if (active) begin
      for (int k = 0; k < 6; k++) begin
        if (rise[k] && (stage_cnt_q[k] != 16'hFFFF)) stage_cnt_d[k] = stage_cnt_q[k] + 16'd1;
      end
      if (stall_now > max_stall_q) max_stall_d = stall_now;
    end
  end

  assign bus.o_stage_cnt = stage_cnt_q;
  assign bus.o_max_stall = max_stall_q;
`endif

endmodule

// File: tb/tb_ariscv_run_sequencer.sv
// tb/tb_ariscv_run_sequencer.sv - directed self-checking bench for ariscv_run_sequencer
// Three instances: general/timeout (WDOG=64), instruction limit (MAX_INSTR=5), saturation (CNT_W=4).
module tb_ariscv_run_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  int   n;

  always #5 clk = ~clk;

  ariscv_run_sequencer_if #(.CNT_W(32)) bus_a ();
  ariscv_run_sequencer_if #(.CNT_W(32)) bus_b ();
  ariscv_run_sequencer_if #(.CNT_W(4))  bus_c ();

  ariscv_run_sequencer #(.WDOG_CYCLES(64)) dut_a (
    .clk(clk), .rst_async(rst), .bus(bus_a)
  );
  ariscv_run_sequencer #(.WDOG_CYCLES(64), .MAX_INSTR(5)) dut_b (
    .clk(clk), .rst_async(rst), .bus(bus_b)
  );
  ariscv_run_sequencer #(.CNT_W(4)) dut_c (
    .clk(clk), .rst_async(rst), .bus(bus_c)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bus_a.i_start = 1'b0; bus_a.i_stop = 1'b0; bus_a.i_aclk = '0;
    bus_b.i_start = 1'b0; bus_b.i_stop = 1'b0; bus_b.i_aclk = '0;
    bus_c.i_start = 1'b0; bus_c.i_stop = 1'b0; bus_c.i_aclk = '0;
    tick(3);
    check_eq("rst_state",   64'(bus_a.o_state), 64'(0));
    check_eq("rst_ctrl",    64'(bus_a.o_ctrl_rst_n), 64'(0));
    check_eq("rst_busy",    64'(bus_a.o_busy), 64'(0));
    check_eq("rst_done",    64'(bus_a.o_done), 64'(0));
    check_eq("rst_timeout", 64'(bus_a.o_timeout), 64'(0));
    check_eq("rst_retired", 64'(bus_a.o_retired), 64'(0));
    rst = 1'b0;
    tick(2);

    // Instruction limit: continuous 4-high/4-low PC pulses until DRAIN.
    bus_b.i_start = 1'b1; tick(1); bus_b.i_start = 1'b0;
    n = 0;
    while (bus_b.o_state != 3'd2 && n < 50) begin tick(1); n++; end
    n = 0;
    while (bus_b.o_state != 3'd3 && n < 200) begin
      bus_b.i_aclk[0] = (n % 8) < 4;
      tick(1);
      n++;
    end
    check_eq("lim_drain_state", 64'(bus_b.o_state), 64'(3));
    check_eq("lim_drain_retired", 64'(bus_b.o_retired), 64'(5));
    bus_b.i_aclk = '0;
    n = 0;
    while (bus_b.o_state != 3'd4 && n < 200) begin tick(1); n++; end
    check_eq("lim_done_state", 64'(bus_b.o_state), 64'(4));
    check_eq("lim_done_pulse", 64'(bus_b.o_done), 64'(1));
    tick(1);
    check_eq("lim_idle_state", 64'(bus_b.o_state), 64'(0));
    check_eq("lim_done_low", 64'(bus_b.o_done), 64'(0));
    check_eq("lim_retired_held", 64'(bus_b.o_retired), 64'(5));

    // Saturation: 4-bit retire counter, 20 pulses.
    bus_c.i_start = 1'b1; tick(1); bus_c.i_start = 1'b0;
    n = 0;
    while (bus_c.o_state != 3'd2 && n < 50) begin tick(1); n++; end
    for (int i = 0; i < 20; i++) begin
      bus_c.i_aclk[0] = 1'b1; tick(4);
      bus_c.i_aclk[0] = 1'b0; tick(4);
    end
    tick(4);
    check_eq("sat_retired", 64'(bus_c.o_retired), 64'(15));
`ifdef ARISCV_SEQ_PERF_EN
    check_eq("sat_stage0_cnt", 64'(bus_c.o_stage_cnt[15:0]), 64'(20));
    check_eq("sat_stage1_cnt", 64'(bus_c.o_stage_cnt[31:16]), 64'(0));
`endif

    // Start: reset held exactly 8 cycles, then RUN with control path released.
    bus_a.i_start = 1'b1; tick(1); bus_a.i_start = 1'b0;
    check_eq("hold_state", 64'(bus_a.o_state), 64'(1));
    check_eq("hold_busy", 64'(bus_a.o_busy), 64'(1));
    n = 0;
    while (bus_a.o_ctrl_rst_n == 1'b0 && n < 100) begin tick(1); n++; end
    check_eq("hold_len", 64'(n), 64'(8));
    check_eq("run_state", 64'(bus_a.o_state), 64'(2));
    for (int i = 0; i < 10; i++) begin
      bus_a.i_aclk[0] = 1'b1; tick(4);
      bus_a.i_aclk[0] = 1'b0; tick(4);
    end
    tick(4);
    check_eq("run_retired", 64'(bus_a.o_retired), 64'(10));

    // Stop with a restart of the quiet count at quiet count 10.
    bus_a.i_stop = 1'b1; tick(1); bus_a.i_stop = 1'b0;
    check_eq("stop_drain", 64'(bus_a.o_state), 64'(3));
    check_eq("drain_ctrl", 64'(bus_a.o_ctrl_rst_n), 64'(1));
    tick(10);
    bus_a.i_aclk[1] = 1'b1;
    tick(6);
    check_eq("drain_restart", 64'(bus_a.o_state), 64'(3));
    n = 0;
    while (bus_a.o_state != 3'd4 && n < 100) begin tick(1); n++; end
    check_eq("drain_to_done", 64'(n), 64'(13));
    check_eq("stop_done_pulse", 64'(bus_a.o_done), 64'(1));
    check_eq("done_ctrl", 64'(bus_a.o_ctrl_rst_n), 64'(0));
    tick(1);
    check_eq("stop_idle", 64'(bus_a.o_state), 64'(0));
    check_eq("stop_retired_held", 64'(bus_a.o_retired), 64'(10));
    bus_a.i_aclk = '0;
    tick(5);

    // Timeout: no activity after release.
    bus_a.i_start = 1'b1; tick(1); bus_a.i_start = 1'b0;
    check_eq("restart_clear", 64'(bus_a.o_retired), 64'(0));
    n = 0;
    while (bus_a.o_state != 3'd2 && n < 100) begin tick(1); n++; end
    n = 0;
    while (bus_a.o_state != 3'd5 && n < 200) begin tick(1); n++; end
    check_eq("wdog_len", 64'(n), 64'(64));
    check_eq("fault_timeout", 64'(bus_a.o_timeout), 64'(1));
    check_eq("fault_ctrl", 64'(bus_a.o_ctrl_rst_n), 64'(0));
    check_eq("fault_busy", 64'(bus_a.o_busy), 64'(0));
    tick(3);
    check_eq("fault_sticky", 64'(bus_a.o_timeout), 64'(1));
    bus_a.i_start = 1'b1; tick(1); bus_a.i_start = 1'b0;
    check_eq("fault_restart_state", 64'(bus_a.o_state), 64'(1));
    check_eq("fault_restart_clear", 64'(bus_a.o_timeout), 64'(0));

    // Priority: stop on the expiry cycle must still give FAULT.
    n = 0;
    while (bus_a.o_state != 3'd2 && n < 100) begin tick(1); n++; end
    tick(63);
    check_eq("prio_pre_state", 64'(bus_a.o_state), 64'(2));
    bus_a.i_stop = 1'b1; tick(1); bus_a.i_stop = 1'b0;
    check_eq("prio_fault", 64'(bus_a.o_state), 64'(5));

    // Asynchronous reset mid-run with 5 retired.
    bus_a.i_start = 1'b1; tick(1); bus_a.i_start = 1'b0;
    n = 0;
    while (bus_a.o_state != 3'd2 && n < 100) begin tick(1); n++; end
    for (int i = 0; i < 5; i++) begin
      bus_a.i_aclk[0] = 1'b1; tick(4);
      bus_a.i_aclk[0] = 1'b0; tick(4);
    end
    tick(4);
    check_eq("mid_retired", 64'(bus_a.o_retired), 64'(5));
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ctrl", 64'(bus_a.o_ctrl_rst_n), 64'(0));
    check_eq("mid_rst_retired", 64'(bus_a.o_retired), 64'(0));
    check_eq("mid_rst_state", 64'(bus_a.o_state), 64'(0));
    check_eq("mid_rst_busy", 64'(bus_a.o_busy), 64'(0));
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
